// File: rtl/discrete_audio_pkg.sv
// Shared definitions for the discrete audio chain (filter, VCO, sample FIFO).
package discrete_audio_pkg;

    // Default sample width shared by the filter and VCO stages
    localparam int unsigned SampleWidth = 16;

    typedef logic signed [SampleWidth-1:0] sample_t;

endpackage

// File: rtl/audio_sample_ram.sv
// DEPTH x WIDTH sample storage: one write port, one registered read port.
// The read register returns the write data when reading the address being
// written in the same cycle, so a freshly written head sample is visible
// one cycle later.
module audio_sample_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AddrW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_we,
    input  logic [AddrW-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AddrW-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage array write; contents need no reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port, write-first on address collision; holds when not enabled
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            if (i_we && (i_waddr == i_raddr)) begin
                r_rdata <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/audio_sample_fifo.sv
// Sample FIFO between the filter stage and the audio consumer.
// level counts every unread sample, including the one presented on out_sample.
// The RAM read register is the output register: it is reloaded with the new
// head whenever the head is consumed or the FIFO goes from empty to non-empty.
module audio_sample_fifo
    import discrete_audio_pkg::*;
#(
    parameter int unsigned WIDTH = SampleWidth,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned LvlW = PtrW + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    audio_clk_en,
    input  logic signed [WIDTH-1:0] in,
    output logic signed [WIDTH-1:0] out_sample,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LvlW-1:0]         level,
    output logic                    overflow
);

    localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [LvlW-1:0]  r_level;
    logic             r_valid;
    logic             r_overflow;

    logic             w_full;
    logic             w_rd;
    logic             w_wr;
    logic             w_load;
    logic             w_ram_we;
    logic             w_ram_re;
    logic [PtrW-1:0]  w_rptr_next;
    logic [LvlW-1:0]  w_level_next;
    logic [WIDTH-1:0] w_rdata;

    // Handshake decode, next read pointer, next occupancy and head reload
    always_comb begin
        w_full      = (r_level == LvlFull);
        w_rd        = r_valid & out_ready;
        // A read in the same cycle frees a slot, so a full FIFO still accepts
        w_wr        = audio_clk_en & (~w_full | w_rd);
        w_rptr_next = r_rptr + PtrW'(w_rd);
        case ({w_wr, w_rd})
            2'b10:   w_level_next = r_level + LvlW'(1);
            2'b01:   w_level_next = r_level - LvlW'(1);
            default: w_level_next = r_level;
        endcase
        w_load      = (w_level_next != '0) & (w_rd | ~r_valid);
        // No storage activity while reset is asserted
        w_ram_we    = w_wr & reset_n;
        w_ram_re    = w_load & reset_n;
    end

    // Pointer, occupancy, valid and sticky overflow state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            r_rptr  <= w_rptr_next;
            r_level <= w_level_next;
            r_valid <= (w_level_next != '0);
            if (audio_clk_en && w_full && !w_rd) begin
                r_overflow <= 1'b1;
            end
        end
    end

    audio_sample_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .i_we     (w_ram_we),
        .i_waddr  (r_wptr),
        .i_wdata  (in),
        .i_re     (w_ram_re),
        .i_raddr  (w_rptr_next),
        .o_rdata  (w_rdata)
    );

    assign out_sample = w_rdata;
    assign out_valid  = r_valid;
    assign level      = r_level;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_audio_sample_fifo;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;

    logic                    clk;
    logic                    reset_n;
    logic                    audio_clk_en;
    logic signed [WIDTH-1:0] din;
    logic signed [WIDTH-1:0] out_sample;
    logic                    out_valid;
    logic                    out_ready;
    logic [3:0]              level;
    logic                    overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                      mq[$];
    bit                      m_ovf;
    logic signed [WIDTH-1:0] m_out;
    bit                      m_rd;
    int                      m_pop;

    // What the DUT handed over on the most recent edge
    bit                      rd_fire;
    logic signed [WIDTH-1:0] rd_val;

    audio_sample_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .audio_clk_en(audio_clk_en),
        .in          (din),
        .out_sample  (out_sample),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle, advance the model, return 1 time unit after the edge
    task automatic tick(input bit en, input int d, input bit rdy, input bit rstn);
        bit wr;
        audio_clk_en = en;
        din          = 16'(d);
        out_ready    = rdy;
        reset_n      = rstn;
        rd_fire      = out_valid && rdy && rstn;
        rd_val       = out_sample;
        @(posedge clk);
        if (!rstn) begin
            mq.delete();
            m_ovf = 1'b0;
            m_out = '0;
            m_rd  = 1'b0;
        end else begin
            m_rd = (mq.size() != 0) && rdy;
            wr   = en && ((mq.size() < DEPTH) || m_rd);
            if (en && !wr) m_ovf = 1'b1;
            if (m_rd) m_pop = mq.pop_front();
            if (wr) mq.push_back(d);
            if (mq.size() != 0) m_out = 16'(mq[0]);
        end
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0);
        tick(1, 55, 1, 0);
        checks++;
        if ({level, out_valid, overflow, out_sample} !== {4'd0, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_state: level=%0d valid=%0b ovf=%0b sample=%0d, want 0 0 0 0",
                     level, out_valid, overflow, out_sample);
        end
    endtask

    task automatic test_basic();
        int exp_q[$];
        int got[$];
        exp_q = '{100, -200, 32767};
        tick(0, 0, 0, 0);
        tick(1, 100, 0, 1);
        checks++;
        if ({out_valid, level, out_sample} !== {1'b1, 4'd1, 16'sd100}) begin
            errors++;
            $display("FAIL basic_first_latency: valid=%0b level=%0d sample=%0d, want 1 1 100",
                     out_valid, level, out_sample);
        end
        tick(1, -200, 0, 1);
        tick(1, 32767, 0, 1);
        checks++;
        if ({out_valid, level, out_sample} !== {1'b1, 4'd3, 16'sd100}) begin
            errors++;
            $display("FAIL basic_three_stored: valid=%0b level=%0d sample=%0d, want 1 3 100",
                     out_valid, level, out_sample);
        end
        for (int i = 0; i < 8 && got.size() < 3; i++) begin
            tick(0, 0, 1, 1);
            if (rd_fire) got.push_back(int'(rd_val));
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL basic_read_count: got %0d reads, want 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] != exp_q[i]) begin
                errors++;
                $display("FAIL basic_read_%0d: got %0d, want %0d", i, got[i], exp_q[i]);
            end
        end
        tick(0, 0, 1, 1);
        checks++;
        if ({out_valid, level, out_sample} !== {1'b0, 4'd0, 16'sd32767}) begin
            errors++;
            $display("FAIL basic_empty_hold: valid=%0b level=%0d sample=%0d, want 0 0 32767",
                     out_valid, level, out_sample);
        end
    endtask

    task automatic test_overflow();
        int got[$];
        tick(0, 0, 0, 0);
        for (int v = 1; v <= 8; v++) tick(1, v, 0, 1);
        checks++;
        if ({level, overflow} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL ovf_full_no_flag: level=%0d ovf=%0b, want 8 0", level, overflow);
        end
        tick(1, 9, 0, 1);
        checks++;
        if ({level, overflow} !== {4'd8, 1'b1}) begin
            errors++;
            $display("FAIL ovf_dropped: level=%0d ovf=%0b, want 8 1", level, overflow);
        end
        for (int i = 0; i < 12 && got.size() < 9; i++) begin
            tick(0, 0, 1, 1);
            if (rd_fire) got.push_back(int'(rd_val));
        end
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL ovf_read_count: got %0d reads, want 8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++;
            if (got[i] != i + 1) begin
                errors++;
                $display("FAIL ovf_read_%0d: got %0d, want %0d", i, got[i], i + 1);
            end
        end
        checks++;
        if ({level, out_valid, overflow} !== {4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_sticky: level=%0d valid=%0b ovf=%0b, want 0 0 1",
                     level, out_valid, overflow);
        end
    endtask

    task automatic test_full_rw();
        int got[$];
        tick(0, 0, 0, 0);
        for (int v = 1; v <= 8; v++) tick(1, v, 0, 1);
        tick(1, -32768, 1, 1);
        checks++;
        if ({level, overflow, out_sample} !== {4'd8, 1'b0, 16'sd2}) begin
            errors++;
            $display("FAIL full_rw: level=%0d ovf=%0b head=%0d, want 8 0 2",
                     level, overflow, out_sample);
        end
        for (int i = 0; i < 12 && got.size() < 9; i++) begin
            tick(0, 0, 1, 1);
            if (rd_fire) got.push_back(int'(rd_val));
        end
        checks++;
        if (got.size() != 8 || got[got.size() - 1] != -32768) begin
            errors++;
            $display("FAIL full_rw_last: got %0d reads last=%0d, want 8 reads last=-32768",
                     got.size(), (got.size() != 0) ? got[got.size() - 1] : 0);
        end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            checks++;
            if (got[i] != i + 2) begin
                errors++;
                $display("FAIL full_rw_read_%0d: got %0d, want %0d", i, got[i], i + 2);
            end
        end
    endtask

    task automatic test_wrap();
        int sent[$];
        int got[$];
        int v;
        tick(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 65535)) - 32768;
            sent.push_back(v);
            tick(1, v, 1, 1);
            if (rd_fire) got.push_back(int'(rd_val));
            checks++;
            if (level > 4'd1) begin
                errors++;
                $display("FAIL wrap_level_%0d: level=%0d, want <=1", i, level);
            end
        end
        for (int i = 0; i < 4 && got.size() < 20; i++) begin
            tick(0, 0, 1, 1);
            if (rd_fire) got.push_back(int'(rd_val));
        end
        checks++;
        if (got.size() != 20) begin
            errors++;
            $display("FAIL wrap_count: got %0d reads, want 20", got.size());
        end
        for (int i = 0; i < 20 && i < got.size(); i++) begin
            checks++;
            if (got[i] != sent[i]) begin
                errors++;
                $display("FAIL wrap_order_%0d: got %0d, want %0d", i, got[i], sent[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        tick(0, 0, 0, 0);
        for (int v = 1; v <= 9; v++) tick(1, v * 11, 0, 1);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 1);
        checks++;
        if ({level, overflow} !== {4'd5, 1'b1}) begin
            errors++;
            $display("FAIL mid_setup: level=%0d ovf=%0b, want 5 1", level, overflow);
        end
        tick(1, 123, 1, 0);
        checks++;
        if ({level, out_valid, overflow, out_sample} !== {4'd0, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL mid_reset: level=%0d valid=%0b ovf=%0b sample=%0d, want 0 0 0 0",
                     level, out_valid, overflow, out_sample);
        end
        tick(0, 0, 0, 1);
        checks++;
        if ({level, out_valid} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_no_write: level=%0d valid=%0b, want 0 0", level, out_valid);
        end
    endtask

    task automatic test_random();
        bit en;
        bit rdy;
        bit rstn;
        tick(0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            en   = ($urandom_range(0, 99) < 60);
            rdy  = ($urandom_range(0, 99) < ((i % 200) < 100 ? 25 : 80));
            rstn = ($urandom_range(0, 249) != 0);
            tick(en, int'($urandom_range(0, 65535)) - 32768, rdy, rstn);
            checks++;
            if (level !== 4'(mq.size()) || out_valid !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL rand_level_%0d: level=%0d valid=%0b, want %0d %0b",
                         i, level, out_valid, mq.size(), mq.size() != 0);
            end
            checks++;
            if (out_sample !== m_out || overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_out_%0d: sample=%0d ovf=%0b, want %0d %0b",
                         i, out_sample, overflow, m_out, m_ovf);
            end
            checks++;
            if (rd_fire != m_rd || (m_rd && int'(rd_val) != m_pop)) begin
                errors++;
                $display("FAIL rand_read_%0d: fired=%0b val=%0d, want %0b %0d",
                         i, rd_fire, rd_val, m_rd, m_pop);
            end
        end
    endtask

    initial begin
        audio_clk_en = 1'b0;
        din          = '0;
        out_ready    = 1'b0;
        reset_n      = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
